// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Each accepted single-beat command drives the RAM pins for one cycle. Read data
// is steered back to its issuer through an RD_LAT-deep {valid, owner} pipeline.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy
);

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  logic              ack_a_reg, ack_b_reg;
  logic              rvalid_a_reg, rvalid_b_reg;
  logic [DATA_W-1:0] rdata_a_reg, rdata_b_reg;
  logic              ram_wr_en_reg, ram_rd_en_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_wr_data_reg;
  logic              busy_reg;
  logic              last_grant_reg;

  logic              elig_a, elig_b;
  logic              grant_a, grant_b, grant_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [RD_LAT-1:0] pipe_valid_reg, pipe_owner_reg;
  logic [RD_LAT-1:0] pipe_valid_next, pipe_owner_next;
  logic              ret_valid, ret_owner;

  // Eligibility masks the request still visible during its own ack cycle;
  // on a conflict the requester that did not win last time goes first.
  always_comb begin
    elig_a    = req_a && !ack_a_reg;
    elig_b    = req_b && !ack_b_reg;
    grant_a   = elig_a && (!elig_b || (last_grant_reg == OWNER_B));
    grant_b   = elig_b && !grant_a;
    grant_any = grant_a || grant_b;
    sel_we    = grant_b ? we_b    : we_a;
    sel_addr  = grant_b ? addr_b  : addr_a;
    sel_wdata = grant_b ? wdata_b : wdata_a;
  end

  // Command issue: acks and RAM pins for exactly one cycle per grant; address holds otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_a_reg       <= 1'b0;
      ack_b_reg       <= 1'b0;
      ram_wr_en_reg   <= 1'b0;
      ram_rd_en_reg   <= 1'b0;
      ram_addr_reg    <= '0;
      ram_wr_data_reg <= '0;
      last_grant_reg  <= OWNER_B;
    end else begin
      ack_a_reg       <= grant_a;
      ack_b_reg       <= grant_b;
      ram_wr_en_reg   <= grant_any && sel_we;
      ram_rd_en_reg   <= grant_any && !sel_we;
      ram_wr_data_reg <= (grant_any && sel_we) ? sel_wdata : '0;
      if (grant_any) begin
        ram_addr_reg   <= sel_addr;
        last_grant_reg <= grant_b ? OWNER_B : OWNER_A;
      end
    end
  end

  // Stage 0 is fed from the read strobe on the RAM pins, so the last stage lines
  // up with the cycle in which ram_rd_data is valid.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_valid_next[gi] = ram_rd_en_reg;
        assign pipe_owner_next[gi] = ack_b_reg;
      end else begin : g_body
        assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
        assign pipe_owner_next[gi] = pipe_owner_reg[gi-1];
      end
    end
  endgenerate

  assign ret_valid = pipe_valid_reg[RD_LAT-1];
  assign ret_owner = pipe_owner_reg[RD_LAT-1];

  // Return pipeline shift; busy mirrors the valid bits it is about to hold.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pipe_valid_reg <= '0;
      pipe_owner_reg <= '0;
      busy_reg       <= 1'b0;
    end else begin
      pipe_valid_reg <= pipe_valid_next;
      pipe_owner_reg <= pipe_owner_next;
      busy_reg       <= |pipe_valid_next;
    end
  end

  // Capture returning data for its owner; rdata holds until that owner's next read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rvalid_a_reg <= 1'b0;
      rvalid_b_reg <= 1'b0;
      rdata_a_reg  <= '0;
      rdata_b_reg  <= '0;
    end else begin
      rvalid_a_reg <= ret_valid && (ret_owner == OWNER_A);
      rvalid_b_reg <= ret_valid && (ret_owner == OWNER_B);
      if (ret_valid && (ret_owner == OWNER_A)) rdata_a_reg <= ram_rd_data;
      if (ret_valid && (ret_owner == OWNER_B)) rdata_b_reg <= ram_rd_data;
    end
  end

  assign ack_a       = ack_a_reg;
  assign ack_b       = ack_b_reg;
  assign rvalid_a    = rvalid_a_reg;
  assign rvalid_b    = rvalid_b_reg;
  assign rdata_a     = rdata_a_reg;
  assign rdata_b     = rdata_b_reg;
  assign ram_wr_en   = ram_wr_en_reg;
  assign ram_rd_en   = ram_rd_en_reg;
  assign ram_addr    = ram_addr_reg;
  assign ram_wr_data = ram_wr_data_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a cycle-level reference model predicts every
// grant and read return into queues; a negedge monitor pops and compares.
module tb_ram_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic req_a, we_a, req_b, we_b;
  logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
  logic ack_a, rvalid_a, ack_b, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic ram_wr_en, ram_rd_en, busy;
  logic [7:0] ram_addr, ram_wr_data, ram_rd_data;

  always #5 sys_clk = ~sys_clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .busy(busy)
  );

  wire [38:0] all_outs = {ack_a, rvalid_a, rdata_a, ack_b, rvalid_b, rdata_b,
                          ram_wr_en, ram_rd_en, ram_addr, ram_wr_data, busy};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Behavioural RAM with RD_LAT read latency
  logic [7:0] ram_mem [256];
  logic [7:0] rd_dly [RD_LAT];
  always @(posedge sys_clk) begin
    if (ram_wr_en) ram_mem[ram_addr] <= ram_wr_data;
    rd_dly[0] <= ram_rd_en ? ram_mem[ram_addr] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_dly[i] <= rd_dly[i-1];
  end
  assign ram_rd_data = rd_dly[RD_LAT-1];

  // Requester drivers: per-side command queues with optional idle gaps
  typedef struct { bit we; logic [7:0] addr; logic [7:0] data; int gap; } req_t;
  req_t dq [2][$];
  req_t pend [2];
  bit   have_pend [2];
  int   wait_cnt [2];
  logic d_req [2];
  logic d_we [2];
  logic [7:0] d_addr [2];
  logic [7:0] d_wdata [2];

  assign req_a = d_req[0];  assign we_a = d_we[0];  assign addr_a = d_addr[0];  assign wdata_a = d_wdata[0];
  assign req_b = d_req[1];  assign we_b = d_we[1];  assign addr_b = d_addr[1];  assign wdata_b = d_wdata[1];

  always @(negedge sys_clk) begin
    for (int s = 0; s < 2; s++) begin
      logic ack_s;
      ack_s = (s == 0) ? ack_a : ack_b;
      if (!sys_rst_n) begin
        d_req[s] = 1'b0;
      end else begin
        if (d_req[s] && ack_s) d_req[s] = 1'b0;
        if (!d_req[s] && !have_pend[s] && dq[s].size() > 0) begin
          pend[s] = dq[s].pop_front();
          have_pend[s] = 1'b1;
          wait_cnt[s] = pend[s].gap;
        end
        if (!d_req[s] && have_pend[s]) begin
          if (wait_cnt[s] == 0) begin
            d_req[s] = 1'b1;  d_we[s] = pend[s].we;
            d_addr[s] = pend[s].addr;  d_wdata[s] = pend[s].data;
            have_pend[s] = 1'b0;
          end else begin
            wait_cnt[s]--;
          end
        end
      end
    end
  end

  // Reference model: predicts which command each cycle carries and when reads return
  typedef struct { int cyc; bit owner; bit we; logic [7:0] addr; logic [7:0] data; } cmd_t;
  typedef struct { int cyc; bit owner; logic [7:0] data; } ret_t;
  cmd_t cq [$];
  ret_t rq [$];
  logic [7:0] ref_mem [256];
  bit m_ack [2];
  bit m_last;

  always @(posedge sys_clk) begin
    bit el [2];
    int w;
    cyc = cyc + 1;
    if (!sys_rst_n) begin
      m_ack[0] = 0;  m_ack[1] = 0;  m_last = 1;
      cq.delete();  rq.delete();
    end else begin
      el[0] = (req_a === 1'b1) && !m_ack[0];
      el[1] = (req_b === 1'b1) && !m_ack[1];
      w = -1;
      if (el[0] && el[1]) w = (m_last == 1) ? 0 : 1;
      else if (el[0]) w = 0;
      else if (el[1]) w = 1;
      m_ack[0] = (w == 0);
      m_ack[1] = (w == 1);
      if (w >= 0) begin
        cmd_t c;
        c.cyc = cyc;  c.owner = w[0];
        c.we   = (w == 0) ? we_a : we_b;
        c.addr = (w == 0) ? addr_a : addr_b;
        c.data = (w == 0) ? wdata_a : wdata_b;
        cq.push_back(c);
        m_last = w[0];
        if (c.we) ref_mem[c.addr] = c.data;
        else rq.push_back('{cyc + RD_LAT + 1, w[0], ref_mem[c.addr]});
      end
    end
  end

  // Monitor: compares the DUT against the head of each expectation queue
  logic [7:0] m_addr, m_rdata_a, m_rdata_b;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      m_addr = 8'h00;  m_rdata_a = 8'h00;  m_rdata_b = 8'h00;
    end else begin
      bit exp_busy;
      exp_busy = 0;
      foreach (rq[i]) if (rq[i].cyc > cyc && rq[i].cyc <= cyc + RD_LAT) exp_busy = 1;
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        cmd_t e;
        e = cq.pop_front();
        m_addr = e.addr;
        check("cmd", {ack_a, ack_b, ram_wr_en, ram_rd_en, ram_addr, ram_wr_data},
              {!e.owner, e.owner, e.we, !e.we, e.addr, e.we ? e.data : 8'h00});
        $display("cyc %0d cmd %s %s addr=%h data=%h", cyc, e.owner ? "B" : "A",
                 e.we ? "wr" : "rd", e.addr, e.we ? e.data : 8'h00);
      end else begin
        check("idle", {ack_a, ack_b, ram_wr_en, ram_rd_en, ram_addr, ram_wr_data},
              {4'b0000, m_addr, 8'h00});
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        ret_t r;
        r = rq.pop_front();
        if (r.owner) m_rdata_b = r.data; else m_rdata_a = r.data;
        check("rvalid", {rvalid_a, rvalid_b, rdata_a, rdata_b},
              {!r.owner, r.owner, m_rdata_a, m_rdata_b});
        $display("cyc %0d ret %s data=%h", cyc, r.owner ? "B" : "A", r.data);
      end else begin
        check("no_rvalid", {rvalid_a, rvalid_b, rdata_a, rdata_b},
              {2'b00, m_rdata_a, m_rdata_b});
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge sys_clk);
      done = dq[0].size() == 0 && dq[1].size() == 0 && !have_pend[0] && !have_pend[1] &&
             d_req[0] !== 1'b1 && d_req[1] !== 1'b1 && cq.size() == 0 && rq.size() == 0;
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  // Release reset with both sides already queued; the first grant must go to A.
  task automatic release_and_check_conflict();
    bit seen;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge sys_clk);
      if (ack_a || ack_b) begin
        seen = 1;
        check("first_conflict", {62'd0, ack_a, ack_b}, {62'd0, 2'b10});
      end
    end
    if (!seen) check("conflict_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    for (int s = 0; s < 2; s++) begin
      d_req[s] = 0;  d_we[s] = 0;  d_addr[s] = 0;  d_wdata[s] = 0;  have_pend[s] = 0;  wait_cnt[s] = 0;
    end
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", {25'd0, all_outs}, 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // A writes 0x5A to 0x10, then B reads it back
    dq[0].push_back('{1'b1, 8'h10, 8'h5A, 0});
    wait_idle(50);
    dq[1].push_back('{1'b0, 8'h10, 8'h00, 0});
    wait_idle(50);

    // B back-to-back reads of 0x00..0x03
    for (int a = 0; a < 4; a++) dq[1].push_back('{1'b0, 8'(a), 8'h00, 0});
    wait_idle(60);

    // A requesting continuously
    for (int i = 0; i < 6; i++) dq[0].push_back('{1'b1, 8'(8'h20 + i), 8'($urandom), 0});
    wait_idle(60);

    // Both request together right after reset: A first, then strict alternation
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dq[0].push_back('{1'b0, 8'(8'h10 + i), 8'h00, 0});
      dq[1].push_back('{1'b1, 8'(8'h30 + i), 8'(8'hA0 + i), 0});
    end
    release_and_check_conflict();
    wait_idle(80);

    // Reset with two reads in flight; A holds the last grant at that point
    dq[1].push_back('{1'b0, 8'h01, 8'h00, 0});
    dq[0].push_back('{1'b0, 8'h02, 8'h00, 1});
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge sys_clk);
      if (ack_a) found = 1;
    end
    if (!found) check("t5_ack_timeout", 64'd0, 64'd1);
    check("t5_busy_before_reset", {63'd0, busy}, 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", {25'd0, all_outs}, 64'd0);
    repeat (3) @(negedge sys_clk);
    dq[0].push_back('{1'b1, 8'h40, 8'h11, 0});
    dq[1].push_back('{1'b1, 8'h41, 8'h22, 0});
    release_and_check_conflict();
    wait_idle(60);

    // Randomized traffic on a narrow address range to force read-after-write hits
    for (int i = 0; i < 120; i++) begin
      dq[0].push_back('{1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3)});
      dq[1].push_back('{1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3)});
    end
    wait_idle(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
